// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button debounce array.
// Hold FSM state encoding plus counter-width functions.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLDING,
    REPEATING,
    DONE
  } hold_st_e;

  function automatic int unsigned cnt_w(input int unsigned v);
    return (v == 0) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int unsigned umax(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 3-flop sync, debounce, press/release, hold FSM.
// Ports: clk, rst, tick_i, raw_i -> state_o, press_o, release_o, long_o, repeat_o.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter int unsigned DEBOUNCE_TICKS = 16384,
  parameter int unsigned HOLD_TICKS     = 0,
  parameter int unsigned REPEAT_TICKS   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DW = cnt_w(DEBOUNCE_TICKS);
  localparam int unsigned HW = cnt_w(umax(HOLD_TICKS, REPEAT_TICKS));
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);

  logic [2:0]    sync_q, sync_d;
  logic          sync_p;
  logic          state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;
  hold_st_e      st_q, st_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  always_comb begin
    sync_d  = {sync_q[1:0], raw_i};
    sync_p  = sync_q[2] ^ ACTIVE_LOW;
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (sync_p == state_q) begin
      dcnt_d = '0;
    end else if (tick_i) begin
      if (dcnt_q == DEB_LAST) begin
        state_d = ~state_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
    press_d = state_d & ~state_q;
    rel_d   = ~state_d & state_q;
  end

  // Release on the same edge as a terminal count wins: the
  // FSM keys off state_d, so no long/repeat pulse is emitted.
  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    long_d = 1'b0;
    rep_d  = 1'b0;
    if (HOLD_TICKS == 0 || !state_d) begin
      st_d   = IDLE;
      hcnt_d = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (press_d) begin
            st_d   = HOLDING;
            hcnt_d = '0;
          end
        end
        HOLDING: begin
          if (tick_i) begin
            if (hcnt_q == HOLD_LAST) begin
              long_d = 1'b1;
              hcnt_d = '0;
              st_d   = (REPEAT_TICKS == 0) ? DONE : REPEATING;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
        end
        REPEATING: begin
          if (tick_i) begin
            if (hcnt_q == REP_LAST) begin
              rep_d  = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
        end
        DONE: begin
          hcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {3{ACTIVE_LOW}};
      state_q <= 1'b0;
      dcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      st_q    <= IDLE;
      hcnt_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      st_q    <= st_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
  assign repeat_o  = rep_q;

endmodule

// File: rtl/button_debounce_array.sv
// N-channel button debouncer with press/release/long/repeat pulses.
// Ports: clk, rst, tick, btn_raw[N] -> btn_state/press/release/long/repeat[N].
module button_debounce_array
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTN        = 8,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter int unsigned DEBOUNCE_TICKS = 16384,
  parameter int unsigned HOLD_TICKS     = 0,
  parameter int unsigned REPEAT_TICKS   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce_channel #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .raw_i    (btn_raw[i]),
      .state_o  (btn_state[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array (2 ch, debounce 4, hold 10, repeat 3).
// Checks packed {state,press,release,long,repeat} each cycle.
module tb_button_debounce_array;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] btn_raw;
  logic [1:0] btn_state;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;
  logic [1:0] btn_repeat;

  int checks;
  int errors;

  button_debounce_array #(
    .NUM_BTN       (2),
    .ACTIVE_LOW    (1'b1),
    .DEBOUNCE_TICKS(4),
    .HOLD_TICKS    (10),
    .REPEAT_TICKS  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] mk(
    input logic [1:0] s,
    input logic [1:0] p,
    input logic [1:0] r,
    input logic [1:0] l,
    input logic [1:0] rp
  );
    return {s, p, r, l, rp};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {btn_state, btn_press, btn_release, btn_long, btn_repeat};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    tick    = 1'b1;
    btn_raw = 2'b11;

    // reset with idle pins
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("reset", i, '0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk("idle", i, '0);
    end

    // press, long, repeats, release (pending repeat suppressed)
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      cyc();
      chk("hold", c, mk({1'b0, c >= 7 && c < 47},
                        {1'b0, c == 7},
                        {1'b0, c == 47},
                        {1'b0, c == 17},
                        {1'b0, c > 17 && c < 47 && (c - 17) % 3 == 0}));
      if (c == 40) btn_raw[0] = 1'b1;
    end

    // 3-cycle glitch never reaches the debounce count
    btn_raw[0] = 1'b0;
    for (int g = 1; g <= 15; g++) begin
      cyc();
      chk("glitch", g, '0);
      if (g == 3) btn_raw[0] = 1'b1;
    end

    // tick 1-in-4 during press debounce
    btn_raw[0] = 1'b0;
    tick = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      cyc();
      chk("tick4", n, mk({1'b0, n >= 16 && n < 23},
                         {1'b0, n == 16},
                         {1'b0, n == 23},
                         2'b00, 2'b00));
      if (n == 16) btn_raw[0] = 1'b1;
      tick = (n >= 16) ? 1'b1 : ((n + 1) % 4 == 0);
    end

    // tick frozen 50 cycles mid-debounce, then into repeating
    btn_raw[0] = 1'b0;
    tick = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      cyc();
      chk("freeze", n, mk({1'b0, n >= 57},
                          {1'b0, n == 57},
                          2'b00,
                          {1'b0, n == 67},
                          {1'b0, n == 70 || n == 73}));
      tick = !((n + 1) >= 6 && (n + 1) <= 55);
    end

    // reset while repeating (a repeat was due this edge)
    rst = 1'b1;
    cyc();
    chk("rst_mid", 0, '0);
    rst = 1'b0;
    for (int m = 1; m <= 20; m++) begin
      cyc();
      chk("after_rst", m, mk({1'b0, m >= 7},
                             {1'b0, m == 7},
                             2'b00,
                             {1'b0, m == 17},
                             {1'b0, m == 20}));
    end

    // channel 1 alone
    rst = 1'b1;
    btn_raw = 2'b01;
    cyc();
    chk("rst_ch1", 0, '0);
    rst = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      cyc();
      chk("ch1", m, mk({m >= 7, 1'b0},
                       {m == 7, 1'b0},
                       2'b00, 2'b00, 2'b00));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce_array.md
Name: button_debounce_array

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Synchronises and debounces N raw button/switch inputs and exposes per-channel stable level plus one-cycle press/release, long-press and auto-repeat event pulses.
- Sits between board pins (d-pad, A/B/Start/Select, menu keys) and the input-mapping and OSD logic. Consumers need no further edge detection.

Parameters:
- NUM_BTN, 8, number of independent channels.
- ACTIVE_LOW, 1, 1 = raw pin low means pressed; 0 = raw high means pressed.
- DEBOUNCE_TICKS, 16384, consecutive ticks the synchronised input must disagree with the filtered state before the state flips (>=1).
- HOLD_TICKS, 0, ticks of continuous press before btn_long pulses; 0 disables long-press and repeat.
- REPEAT_TICKS, 0, period of btn_repeat after btn_long while still held; 0 disables repeat.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  timebase enable; all counters advance only when tick=1 (tie 1 for per-clock counting).
- btn_raw  in  NUM_BTN  asynchronous raw pin levels.
- btn_state  out  NUM_BTN  debounced level, 1 = pressed (polarity-normalised).
- btn_press  out  NUM_BTN  1-cycle pulse, released->pressed.
- btn_release  out  NUM_BTN  1-cycle pulse, pressed->released.
- btn_long  out  NUM_BTN  1-cycle pulse when hold reaches HOLD_TICKS.
- btn_repeat  out  NUM_BTN  1-cycle pulse every REPEAT_TICKS after btn_long while held.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs 0. Debounce/hold/repeat counters 0. All 3 synchroniser flops load the released pin level (1 if ACTIVE_LOW, else 0). No press pulse may follow reset deassert while a pin is idle.
- Channels are fully independent and have identical logic.
- Sync: 3-flop shift per channel, then polarity normalisation: sync_p = s[2] XOR ACTIVE_LOW.
- Debounce counter, width clog2(DEBOUNCE_TICKS+1), evaluated every clk:
  - If sync_p == btn_state, the counter clears regardless of tick.
  - Else, on tick, the counter increments.
  - When it would reach DEBOUNCE_TICKS, btn_state toggles and the counter clears in the same edge.
- A glitch shorter than DEBOUNCE_TICKS ticks never changes btn_state.
- Latency with tick=1: 3 + DEBOUNCE_TICKS clk from a stable raw change to the btn_state change.
- btn_press/btn_release are registered. Each is high for exactly the one cycle in which btn_state first shows its new value.
- Hold FSM per channel: IDLE, HOLDING, REPEATING.
  - IDLE -> HOLDING on the btn_state 0->1 edge, with the hold counter cleared.
  - HOLDING: the hold counter increments on tick. On reaching HOLD_TICKS, pulse btn_long, clear the counter and go to REPEATING (or IDLE-latched if REPEAT_TICKS=0, i.e. no further events until release).
  - REPEATING: the counter increments on tick. On reaching REPEAT_TICKS, pulse btn_repeat, clear the counter and stay.
  - Any state -> IDLE when btn_state=0. Release in the same edge as a pending long/repeat terminal count suppresses that pulse.
- HOLD_TICKS=0: the FSM stays in IDLE and btn_long/btn_repeat are constantly 0.
- Hold and repeat counters are sized to clog2(max+1). They saturate-free by construction, since they clear at terminal count and never wrap.
- tick=0 freezes all counters but not the synchronisers or the debounce equality-clear.
- rst mid-operation returns to the reset values above on the next edge. No pulse is emitted in that cycle.

Decomposition:
- Package button_pkg:
  - hold FSM state enum (IDLE, HOLDING, REPEATING, DONE);
  - localparam width helper function for counter sizing.
- Sub-module button_debounce_channel: one channel (sync, debounce, pulses, hold FSM).
- Top: generate-for over NUM_BTN, bit-slicing the ports.

Test Plan (NUM_BTN=2, ACTIVE_LOW=1, DEBOUNCE_TICKS=4, HOLD_TICKS=10, REPEAT_TICKS=3, tick=1 unless noted):
- Reset with btn_raw=2'b11 held -> all outputs 0 for 20 cycles after rst deassert; no btn_press.
- btn_raw[0] 1->0 held -> btn_state[0]=1 exactly 7 clk later, with btn_press[0] high that cycle only. btn_raw[1] unaffected, all ch1 outputs stay 0.
- btn_raw[0] low pulse of 3 cycles, then high -> btn_state[0] never asserts; no pulses.
- Hold btn_raw[0]=0 for 40 cycles -> btn_long[0] 10 cycles after btn_press[0], then btn_repeat[0] at +3, +6, +9 ...; release -> btn_release[0] 7 cycles after raw rise, and repeats stop.
- tick asserted 1-in-4 cycles, press held -> btn_state rises after 4 ticks (~16 clk + sync). Dropping tick for 50 cycles mid-debounce freezes progress.
- Assert rst while in REPEATING with the button held -> outputs 0 next cycle. After deassert, a fresh btn_press follows 7 cycles later, and the hold count restarts from 0.
